// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// shift_sequencer : multi-cycle shift/rotate, at most STEP bits per clock. Rev 1.0
// ============================================================================
module shift_sequencer #(
  parameter int STEP  = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic [WIDTH-1:0] Rz,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  localparam logic [2:0] c_OP_SHR  = 3'b000;
  localparam logic [2:0] c_OP_SHRA = 3'b001;
  localparam logic [2:0] c_OP_SHL  = 3'b010;
  localparam logic [2:0] c_OP_ROR  = 3'b011;
  localparam logic [2:0] c_OP_ROL  = 3'b100;

  localparam int         c_SW   = $clog2(STEP + 1);
  localparam logic [5:0] c_STEP = 6'(STEP);

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   rz_q, rz_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2:0]         opr_q, opr_d;
  logic               done_q, done_d;

  logic               accept_w;
  logic [c_SW-1:0]    s_w;
  logic [2*WIDTH-1:0] ror_w, rol_w;
  logic [WIDTH-1:0]   f_w;
  logic               unused_rb;

  assign unused_rb = ^Rb[WIDTH-1:5];

  // A request is refused in the done cycle even though the FSM is already IDLE.
  assign accept_w = (state_q == c_IDLE) && start && !done_q;

  // Shift distance is bounded by STEP, so the barrel only spans c_SW amount bits.
  assign s_w   = ({1'b0, cnt_q} > c_STEP) ? c_SW'(c_STEP) : c_SW'(cnt_q);
  assign ror_w = {acc_q, acc_q} >> s_w;
  assign rol_w = {acc_q, acc_q} << s_w;

  always_comb begin
    f_w = acc_q;
    case (opr_q)
      c_OP_SHR:  f_w = acc_q >> s_w;
      c_OP_SHRA: f_w = WIDTH'($signed(acc_q) >>> s_w);
      c_OP_SHL:  f_w = acc_q << s_w;
      c_OP_ROR:  f_w = ror_w[WIDTH-1:0];
      c_OP_ROL:  f_w = rol_w[2*WIDTH-1:WIDTH];
      default:   f_w = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (accept_w) state_d = c_RUN;
      c_RUN:   if (cnt_q == 5'd0) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    opr_d  = opr_q;
    rz_d   = rz_q;
    done_d = 1'b0;
    if (accept_w) begin
      acc_d = Ra;
      opr_d = op;
      cnt_d = (op > c_OP_ROL) ? 5'd0 : Rb[4:0];
    end else if (state_q == c_RUN) begin
      if (cnt_q != 5'd0) begin
        acc_d = f_w;
        cnt_d = cnt_q - 5'(s_w);
      end else begin
        rz_d   = acc_q;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      opr_q  <= '0;
      rz_q   <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      opr_q  <= opr_d;
      rz_q   <= rz_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    busy = (state_q == c_RUN);
    done = done_q;
    Rz   = rz_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// tb_shift_sequencer : directed bench for STEP=8 and STEP=1 instances. Rev 1.0
// ============================================================================
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start8, start1;
  logic [2:0]  op;
  logic [31:0] Ra, Rb;
  logic [31:0] rz8, rz1;
  logic        busy8, busy1, done8, done1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.STEP(8), .WIDTH(32)) u8 (
    .clk(clk), .clr_n(clr_n), .start(start8), .op(op), .Ra(Ra), .Rb(Rb),
    .Rz(rz8), .busy(busy8), .done(done8)
  );

  shift_sequencer #(.STEP(1), .WIDTH(32)) u1 (
    .clk(clk), .clr_n(clr_n), .start(start1), .op(op), .Ra(Ra), .Rb(Rb),
    .Rz(rz1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input bit s1);
    return s1 ? done1 : done8;
  endfunction

  function automatic logic busy_of(input bit s1);
    return s1 ? busy1 : busy8;
  endfunction

  function automatic logic [31:0] rz_of(input bit s1);
    return s1 ? rz1 : rz8;
  endfunction

  // One request on the selected instance; checks latency, busy span, result, single done.
  task automatic run(input bit s1, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int k,
                     input string tag);
    int n;
    int bc;
    bit seen;
    op = o; Ra = a; Rb = b;
    if (s1) start1 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start8 = 1'b0;
    n = 0; bc = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      if (busy_of(s1)) bc++;
      @(posedge clk); #1;
      n++;
      if (done_of(s1)) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(n), 32'(k + 1));
    check({tag, " busy_cycles"}, 32'(bc), 32'(k + 1));
    check({tag, " Rz"}, rz_of(s1), exp);
    check({tag, " busy_in_done"}, 32'(busy_of(s1)), 32'd0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 32'(done_of(s1)), 32'd0);
    check({tag, " Rz_hold"}, rz_of(s1), exp);
  endtask

  logic [2:0]  c_op [4];
  logic [31:0] c_ra [4];
  logic [31:0] c_rb [4];
  logic [31:0] c_ex [4];
  int          c_k  [4];

  initial begin
    int n;
    int dn;
    bit seen;
    bit junked;

    clr_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    op = 3'b000; Ra = 32'h0; Rb = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset Rz8", rz8, 32'h0);
    check("reset busy8", 32'(busy8), 32'd0);
    check("reset done8", 32'(done8), 32'd0);
    check("reset Rz1", rz1, 32'h0);
    check("reset busy1", 32'(busy1), 32'd0);
    check("reset done1", 32'(done1), 32'd0);
    clr_n = 1'b1;
    @(posedge clk); #1;

    run(1'b0, 3'b011, 32'h8000_0001, 32'd1,          32'hC000_0000, 1, "ror1");
    run(1'b0, 3'b001, 32'h8000_0000, 32'd4,          32'hF800_0000, 1, "shra4");
    run(1'b0, 3'b000, 32'h8000_0000, 32'd4,          32'h0800_0000, 1, "shr4");
    run(1'b0, 3'b010, 32'h0000_FFFF, 32'hFFFF_FF14,  32'hFFF0_0000, 3, "shl20_s8");
    run(1'b1, 3'b010, 32'h0000_FFFF, 32'hFFFF_FF14,  32'hFFF0_0000, 20, "shl20_s1");
    run(1'b0, 3'b100, 32'h8000_0001, 32'd4,          32'h0000_0018, 1, "rol4");
    run(1'b0, 3'b001, 32'h8765_4321, 32'hFFFF_FFE0,  32'h8765_4321, 0, "amt0");
    run(1'b0, 3'b111, 32'h1357_9BDF, 32'd5,          32'h1357_9BDF, 0, "pass111");
    run(1'b0, 3'b001, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 4, "shra31");

    // start held high: operands become junk once accepted, so any capture
    // outside IDLE (including the done cycle) would corrupt a result.
    c_op[0] = 3'b000; c_ra[0] = 32'hF0F0_0000; c_rb[0] = 32'd12; c_ex[0] = 32'h000F_0F00; c_k[0] = 2;
    c_op[1] = 3'b100; c_ra[1] = 32'h1234_5678; c_rb[1] = 32'd8;  c_ex[1] = 32'h3456_7812; c_k[1] = 1;
    c_op[2] = 3'b001; c_ra[2] = 32'h8000_0000; c_rb[2] = 32'd31; c_ex[2] = 32'hFFFF_FFFF; c_k[2] = 4;
    c_op[3] = 3'b101; c_ra[3] = 32'hDEAD_BEEF; c_rb[3] = 32'd9;  c_ex[3] = 32'hDEAD_BEEF; c_k[3] = 0;
    start8 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      op = c_op[j]; Ra = c_ra[j]; Rb = c_rb[j];
      n = 0; dn = 0; seen = 1'b0; junked = 1'b0;
      while (!seen && n < 60) begin
        @(posedge clk); #1;
        n++;
        if (busy8 && !junked) begin
          op = 3'b010; Ra = 32'hAAAA_AAAA; Rb = 32'd3; junked = 1'b1;
        end
        if (done8) begin seen = 1'b1; dn++; end
      end
      check($sformatf("cont%0d latency", j), 32'(n), 32'(c_k[j] + 2));
      check($sformatf("cont%0d Rz", j), rz8, c_ex[j]);
      @(posedge clk); #1;
      if (done8) dn++;
      check($sformatf("cont%0d done_count", j), 32'(dn), 32'd1);
      check($sformatf("cont%0d not_accepted_in_done", j), 32'(busy8), 32'd0);
    end
    start8 = 1'b0;
    @(posedge clk); #1;

    // Asynchronous abort mid-run.
    op = 3'b011; Ra = 32'h1234_5678; Rb = 32'd31; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("pre_abort busy1", 32'(busy1), 32'd1);
    clr_n = 1'b0;
    #1;
    check("abort Rz1", rz1, 32'h0);
    check("abort busy1", 32'(busy1), 32'd0);
    check("abort done1", 32'(done1), 32'd0);
    check("abort Rz8", rz8, 32'h0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done1 || busy1) dn++;
    end
    check("no_stale_done", 32'(dn), 32'd0);
    run(1'b1, 3'b011, 32'h8000_0001, 32'd31, 32'h0000_0003, 31, "ror31_s1");
    run(1'b0, 3'b011, 32'h8000_0001, 32'd31, 32'h0000_0003, 4,  "ror31_s8");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift/rotate controller for the ALU shift path.
- Captures one operand and a shift amount under a start/done handshake.
- Applies the shift in chunks of at most STEP bits per clock, using an internal bounded barrel stage rather than a full 32-way mux.
- Sits beside the ALU. The control unit pulses start, waits for done, then latches Rz into the Z register.

Parameters:
- STEP, 8, maximum bits shifted per RUN cycle; power of two, legal values 1 to 16.
- WIDTH, 32, datapath width; only 32 is verified.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation select: 000 SHR (logical right), 001 SHRA (arithmetic right), 010 SHL, 011 ROR, 100 ROL; 101 to 111 are pass-through.
- Ra  input  WIDTH  operand.
- Rb  input  WIDTH  amount source; only Rb[4:0] is used, upper bits are ignored.
- Rz  output  WIDTH  result register.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (clr_n low, asynchronous):
  - State becomes IDLE.
  - Rz, busy, done, the accumulator and the count all become 0.
  - Reset asserted mid-operation aborts the operation; no done pulse follows.
- States: IDLE and RUN.
- IDLE with start high, on a clock edge:
  - acc <= Ra; cnt <= Rb[4:0]; opr <= op.
  - Next state is RUN; busy goes high.
  - Ra, Rb and op may change freely after this capture edge.
- IDLE with start low: hold all registers; done is 0.
- RUN with cnt != 0:
  - s = min(cnt, STEP).
  - acc <= f(opr, acc, s); cnt <= cnt - s.
- RUN with cnt == 0:
  - Rz <= acc; done <= 1; busy <= 0; next state is IDLE.
- done is high for exactly one cycle and is 0 in every other cycle.
- f, per opr:
  - SHR: zeros fill from the MSB side.
  - SHRA: copies of acc[31] fill from the MSB side.
  - SHL: zeros fill from the LSB side.
  - ROR: bits leaving bit 0 re-enter at bit 31.
  - ROL: bits leaving bit 31 re-enter at bit 0.
  - Pass-through codes (101 to 111): the count is forced to 0 at capture; the result is Ra unchanged.
- Chunking equivalence: the composed result equals a single shift or rotate by the full amount. For rotates, amount modulo 32 is inherent in the 5-bit count.
- Latency:
  - k = ceil(amount / STEP), with k = 0 when the amount is 0 or op is a pass-through code.
  - done and the new Rz are visible after the (k+1)-th rising edge following the edge that captured start.
  - Worst case with the defaults (amount 31, STEP 8): k = 4.
- start while busy or while done is high: ignored, not queued. The next request is accepted in the first cycle after done, i.e. back in IDLE.
- Rz holds its value between operations and changes only in the done cycle.
- No combinational path from any input to any output; all outputs are registers.

Test Plan:
- Reset, then ROR with Ra=0x80000001, Rb=1 (STEP=8) -> k=1; done pulses one cycle, 2 edges after capture; Rz=0xC0000000; busy high for exactly 2 cycles.
- SHRA with Ra=0x80000000, Rb=4 -> Rz=0xF8000000. SHR with the same inputs -> Rz=0x08000000.
- SHL with Ra=0x0000FFFF, Rb=0xFFFFFF14 (amount 20, upper bits ignored), STEP=8 -> k=3; done on the 4th edge after capture; Rz=0xFFF00000. Rerun with STEP=1 -> done on the 21st edge, same Rz.
- ROL with Ra=0x80000001, Rb=4 -> Rz=0x00000018. Amount 0 with any op, and op=111 -> done on the 1st edge after capture, Rz=Ra.
- Hold start high continuously with alternating operands -> each request is captured only in IDLE; start during RUN or the done cycle is ignored; exactly one done per accepted request; results match a reference model.
- Drop clr_n mid-RUN (ROR, amount 31, STEP=1, 10 cycles in) -> Rz, busy and done all go to 0 immediately with no clock. After release, a new request completes normally with no stale done pulse.
